// File: rtl/python_word_tx_if.sv
// Handshake and word bus between the pixel source, the word transmitter and the serializer.
interface python_word_tx_if #(
  parameter int CHANNEL_NUM = 4,
  parameter int DATA_WIDTH  = 10
);
  logic                              i_start;
  logic                              i_train_en;
  logic [CHANNEL_NUM*DATA_WIDTH-1:0] iv_pix_data;
  logic                              i_pix_valid;
  logic                              o_pix_ready;
  logic [CHANNEL_NUM*DATA_WIDTH-1:0] ov_data;
  logic [DATA_WIDTH-1:0]             ov_ctrl;
  logic                              o_busy;
  logic                              o_frame_done;
  logic                              o_underflow;

  modport slave (
    input  i_start, i_train_en, iv_pix_data, i_pix_valid,
    output o_pix_ready, ov_data, ov_ctrl, o_busy, o_frame_done, o_underflow
  );

  modport master (
    output i_start, i_train_en, iv_pix_data, i_pix_valid,
    input  o_pix_ready, ov_data, ov_ctrl, o_busy, o_frame_done, o_underflow
  );
endinterface

// File: rtl/python_word_tx.sv
// Frame/line word generator: wraps pixel kernels with FS/LS/LE/FE sync words and line blanking.
module python_word_tx #(
  parameter int CHANNEL_NUM  = 4,
  parameter int DATA_WIDTH   = 10,
  parameter int LINE_KERNELS = 16,
  parameter int FRAME_LINES  = 16,
  parameter int LINE_GAP     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  python_word_tx_if.slave        bus
);
  localparam int DBW = CHANNEL_NUM * DATA_WIDTH;

  // Sync codes are defined for 10-bit words; narrower words truncate, wider ones zero-extend.
  function automatic logic [DATA_WIDTH-1:0] code(input logic [9:0] c);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_WIDTH && i < 10; i++) r[i] = c[i];
    return r;
  endfunction

  localparam logic [DATA_WIDTH-1:0] FS  = code(10'h2AA);
  localparam logic [DATA_WIDTH-1:0] FE  = code(10'h3AA);
  localparam logic [DATA_WIDTH-1:0] LS  = code(10'h0AA);
  localparam logic [DATA_WIDTH-1:0] LE  = code(10'h12A);
  localparam logic [DATA_WIDTH-1:0] BL  = code(10'h015);
  localparam logic [DATA_WIDTH-1:0] IMG = code(10'h035);
  localparam logic [DATA_WIDTH-1:0] TR  = code(10'h3A6);
  localparam logic [DBW-1:0]        TR_ALL = {CHANNEL_NUM{TR}};

  localparam logic [15:0] K_LAST = 16'(LINE_KERNELS - 1);
  localparam logic [15:0] L_LAST = 16'(FRAME_LINES - 1);
  localparam logic [15:0] G_LAST = 16'(LINE_GAP - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] GAP    = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [15:0]           lcnt_q, lcnt_d;
  logic [15:0]           kcnt_q, kcnt_d;
  logic [DBW-1:0]        data_q, data_d;
  logic [DATA_WIDTH-1:0] ctrl_q, ctrl_d;
  logic                  done_q, done_d;
  logic                  under_q, under_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    lcnt_d  = lcnt_q;
    kcnt_d  = kcnt_q;
    data_d  = TR_ALL;
    ctrl_d  = BL;
    done_d  = 1'b0;
    under_d = under_q;
    case (state_q)
      IDLE: begin
        ctrl_d = bus.i_train_en ? TR : BL;
        if (bus.i_start) begin
          state_d = ACTIVE;
          lcnt_d  = '0;
          kcnt_d  = '0;
          under_d = 1'b0;
        end
      end
      ACTIVE: begin
        // The sensor stream cannot stall: a missing kernel becomes a training word and is flagged.
        if (bus.i_pix_valid) data_d = bus.iv_pix_data;
        else                 under_d = 1'b1;
        if (kcnt_q == '0)          ctrl_d = (lcnt_q == '0) ? FS : LS;
        else if (kcnt_q == K_LAST) ctrl_d = (lcnt_q == L_LAST) ? FE : LE;
        else                       ctrl_d = IMG;
        if (kcnt_q == K_LAST) begin
          kcnt_d  = '0;
          state_d = GAP;
        end else begin
          kcnt_d = kcnt_q + 16'd1;
        end
      end
      GAP: begin
        // kcnt doubles as the blanking counter while in GAP.
        if (kcnt_q == G_LAST) begin
          kcnt_d = '0;
          if (lcnt_q == L_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            lcnt_d  = lcnt_q + 16'd1;
            state_d = ACTIVE;
          end
        end else begin
          kcnt_d = kcnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
    if (reset) begin
      state_q <= IDLE;
      lcnt_q  <= '0;
      kcnt_q  <= '0;
      data_q  <= TR_ALL;
      ctrl_q  <= BL;
      done_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
      kcnt_q  <= kcnt_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      done_q  <= done_d;
      under_q <= under_d;
    end
  end

  assign bus.o_pix_ready  = (state_q == ACTIVE);
  assign bus.o_busy       = (state_q != IDLE);
  assign bus.ov_data      = data_q;
  assign bus.ov_ctrl      = ctrl_q;
  assign bus.o_frame_done = done_q;
  assign bus.o_underflow  = under_q;
endmodule

// File: tb/tb_python_word_tx.sv
// Directed bench: vector table for reset/idle/start behaviour, then full-frame, abort and short-frame sequences.
module tb_python_word_tx;
  localparam logic [9:0] FS  = 10'h2AA;
  localparam logic [9:0] FE  = 10'h3AA;
  localparam logic [9:0] LS  = 10'h0AA;
  localparam logic [9:0] LE  = 10'h12A;
  localparam logic [9:0] BL  = 10'h015;
  localparam logic [9:0] IMG = 10'h035;
  localparam logic [9:0] TR  = 10'h3A6;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [39:0] tr_all;

  always #5 clk = ~clk;

  python_word_tx_if #(.CHANNEL_NUM(4), .DATA_WIDTH(10)) b1 ();
  python_word_tx_if #(.CHANNEL_NUM(4), .DATA_WIDTH(10)) b2 ();

  python_word_tx u_dut (.clk(clk), .reset(reset), .bus(b1));

  python_word_tx #(
    .CHANNEL_NUM(4), .DATA_WIDTH(10), .LINE_KERNELS(2), .FRAME_LINES(1), .LINE_GAP(4)
  ) u_short (.clk(clk), .reset(reset), .bus(b2));

  typedef struct {
    logic        rst;
    logic        start;
    logic        train;
    logic        valid;
    logic [39:0] pix;
    logic [9:0]  e_ctrl;
    logic [39:0] e_data;
    logic        e_busy;
    logic        e_ready;
    logic        e_under;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock, then settle 1 ns past the edge before driving or sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected sync word for cycle t of a default-parameter frame (16 kernels + 4 gap per line).
  function automatic logic [9:0] exp_ctrl(input int t);
    int l;
    int p;
    l = t / 20;
    p = t % 20;
    if (p >= 16) return BL;
    if (p == 0)  return (l == 0) ? FS : LS;
    if (p == 15) return (l == 15) ? FE : LE;
    return IMG;
  endfunction

  initial begin
    logic [39:0] pix;
    logic        valid;
    tr_all = {4{TR}};

    reset = 1'b1;
    b1.i_start = 0; b1.i_train_en = 0; b1.i_pix_valid = 0; b1.iv_pix_data = '0;
    b2.i_start = 0; b2.i_train_en = 0; b2.i_pix_valid = 0; b2.iv_pix_data = '0;

    //          rst start train valid pix               ctrl  data            busy ready under
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 40'h0,          BL,  tr_all,         1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 40'h0,          TR,  tr_all,         1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 40'h0,          BL,  tr_all,         1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 40'h0,          TR,  tr_all,         1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 40'h0123456789, FS,  40'h0123456789, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 40'hAAAAA55555, IMG, 40'hAAAAA55555, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 40'h0,          IMG, tr_all,         1'b1, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 40'h0,          BL,  tr_all,         1'b0, 1'b0, 1'b0};

    step();
    for (int i = 0; i < 8; i++) begin
      reset          = vecs[i].rst;
      b1.i_start     = vecs[i].start;
      b1.i_train_en  = vecs[i].train;
      b1.i_pix_valid = vecs[i].valid;
      b1.iv_pix_data = vecs[i].pix;
      step();
      check($sformatf("vec%0d ctrl", i),  b1.ov_ctrl,     vecs[i].e_ctrl);
      check($sformatf("vec%0d data", i),  b1.ov_data,     vecs[i].e_data);
      check($sformatf("vec%0d busy", i),  b1.o_busy,      vecs[i].e_busy);
      check($sformatf("vec%0d ready", i), b1.o_pix_ready, vecs[i].e_ready);
      check($sformatf("vec%0d under", i), b1.o_underflow, vecs[i].e_under);
    end

    // Full default frame: underflow on line 3 kernel 5, a stray start mid-frame.
    reset = 1'b0; b1.i_start = 0; b1.i_train_en = 0; b1.i_pix_valid = 0;
    step();
    b1.i_start = 1'b1;
    step();
    for (int t = 0; t < 320; t++) begin
      pix   = {8'(t), 32'(t * 7 + 1)};
      valid = (t != 65);
      b1.i_start     = (t == 100);
      b1.i_pix_valid = valid;
      b1.iv_pix_data = pix;
      step();
      check($sformatf("frame t%0d ctrl", t), b1.ov_ctrl, exp_ctrl(t));
      check($sformatf("frame t%0d data", t), b1.ov_data,
            ((t % 20) < 16 && valid) ? pix : tr_all);
      check($sformatf("frame t%0d done", t), b1.o_frame_done, (t == 319));
      check($sformatf("frame t%0d busy", t), b1.o_busy, (t != 319));
      check($sformatf("frame t%0d ready", t), b1.o_pix_ready,
            ((t + 1) < 320) && (((t + 1) % 20) < 16));
      check($sformatf("frame t%0d under", t), b1.o_underflow, (t >= 65));
    end
    b1.i_start = 1'b0; b1.i_pix_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post-frame done", b1.o_frame_done, 1'b0);
      check("post-frame busy", b1.o_busy, 1'b0);
      check("post-frame ctrl", b1.ov_ctrl, BL);
      check("post-frame under", b1.o_underflow, 1'b1);
    end

    // Abort at line 7 kernel 5, then restart with FS.
    b1.i_start = 1'b1;
    step();
    check("restart clears under", b1.o_underflow, 1'b0);
    b1.i_start = 1'b0; b1.i_pix_valid = 1'b1;
    for (int t = 0; t < 145; t++) step();
    reset = 1'b1;
    step();
    check("abort ctrl", b1.ov_ctrl, BL);
    check("abort busy", b1.o_busy, 1'b0);
    check("abort ready", b1.o_pix_ready, 1'b0);
    check("abort data", b1.ov_data, tr_all);
    check("abort done", b1.o_frame_done, 1'b0);
    reset = 1'b0;
    b1.i_pix_valid = 1'b0;
    step();
    check("abort idle done", b1.o_frame_done, 1'b0);
    check("abort idle busy", b1.o_busy, 1'b0);
    b1.i_start = 1'b1;
    step();
    b1.i_start = 1'b0; b1.i_pix_valid = 1'b1; b1.iv_pix_data = 40'h0123456789;
    step();
    check("after abort FS", b1.ov_ctrl, FS);
    check("after abort data", b1.ov_data, 40'h0123456789);
    b1.i_pix_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();

    // One-line, two-kernel frame on the short instance.
    b2.i_start = 1'b1;
    step();
    check("short busy", b2.o_busy, 1'b1);
    b2.i_start = 1'b0; b2.i_pix_valid = 1'b1; b2.iv_pix_data = 40'h0123456789;
    step();
    check("short FS", b2.ov_ctrl, FS);
    check("short data", b2.ov_data, 40'h0123456789);
    step();
    check("short FE", b2.ov_ctrl, FE);
    b2.i_pix_valid = 1'b0;
    for (int g = 0; g < 4; g++) begin
      step();
      check($sformatf("short gap%0d ctrl", g), b2.ov_ctrl, BL);
      check($sformatf("short gap%0d done", g), b2.o_frame_done, (g == 3));
      check($sformatf("short gap%0d busy", g), b2.o_busy, (g != 3));
    end
    step();
    check("short done clears", b2.o_frame_done, 1'b0);
    check("short under", b2.o_underflow, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/python_word_tx.md
PYTHON_WORD_TX -- requirements
Module: python_word_tx

Interface
REQ-001 The module SHALL have parameter CHANNEL_NUM, default 4, meaning the number of data channels.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 10, meaning the bits per word per channel.
REQ-003 The module SHALL have parameter LINE_KERNELS, default 16, meaning kernels (cycles) per line; legal range 2..65535.
REQ-004 The module SHALL have parameter FRAME_LINES, default 16, meaning lines per frame; legal range 1..65535.
REQ-005 The module SHALL have parameter LINE_GAP, default 4, meaning blanking cycles after each line; legal range 1..65535.
REQ-006 The module SHALL have port clk, input, 1 bit: the single word clock; one clock, with all logic on its rising edge.
REQ-007 The module SHALL have port reset, input, 1 bit: the reset, which is synchronous and active-high.
REQ-008 The module SHALL have port i_start, input, 1 bit: frame request, sampled only in IDLE.
REQ-009 The module SHALL have port i_train_en, input, 1 bit: when high in IDLE, the sync channel carries the training word.
REQ-010 The module SHALL have port iv_pix_data, input, CHANNEL_NUM*DATA_WIDTH bits: one kernel, with channel 0 in the LSBs.
REQ-011 The module SHALL have port i_pix_valid, input, 1 bit: the upstream kernel is valid.
REQ-012 The module SHALL have port o_pix_ready, output, 1 bit: a kernel is accepted this cycle when i_pix_valid and o_pix_ready are both high.
REQ-013 The module SHALL have port ov_data, output, CHANNEL_NUM*DATA_WIDTH bits: registered parallel data words to the serializer.
REQ-014 The module SHALL have port ov_ctrl, output, DATA_WIDTH bits: registered sync-channel word.
REQ-015 The module SHALL have port o_busy, output, 1 bit: high whenever the state is not IDLE.
REQ-016 The module SHALL have port o_frame_done, output, 1 bit: one-cycle pulse.
REQ-017 The module SHALL have port o_underflow, output, 1 bit: sticky flag.

Function
REQ-018 Code words SHALL be: FS=10'h2AA, FE=10'h3AA, LS=10'h0AA, LE=10'h12A, BL=10'h015, IMG=10'h035, TR=10'h3A6 (for DATA_WIDTH=10; truncated or zero-extended to DATA_WIDTH otherwise).
REQ-019 The FSM SHALL have states IDLE, ACTIVE and GAP; line counter lcnt and kernel counter kcnt are both 16 bits.
REQ-020 In IDLE: o_pix_ready=0; next ov_data = TR on every channel; next ov_ctrl = TR if i_train_en else BL.
REQ-021 In IDLE, if i_start=1, the FSM SHALL go to ACTIVE, clear lcnt and kcnt, and not assert o_busy until the next cycle.
REQ-022 In ACTIVE: o_pix_ready=1 (combinational from state); each cycle consumes one kernel slot whether or not i_pix_valid is high, because the sensor stream cannot stall.
REQ-023 In ACTIVE, the registered ov_data SHALL equal iv_pix_data when i_pix_valid=1, giving 1-cycle latency from acceptance to output.
REQ-024 In ACTIVE with i_pix_valid=0, ov_data SHALL be TR on every channel and o_underflow SHALL be set; o_underflow is cleared only by reset or by i_start accepted in IDLE.
REQ-025 In ACTIVE, the registered ov_ctrl SHALL be selected by priority: kcnt=0 and lcnt=0 -> FS; kcnt=0 -> LS; kcnt=LINE_KERNELS-1 and lcnt=FRAME_LINES-1 -> FE; kcnt=LINE_KERNELS-1 -> LE; otherwise IMG.
REQ-026 In ACTIVE, when kcnt=LINE_KERNELS-1, the FSM SHALL clear kcnt and go to GAP; otherwise it SHALL increment kcnt.
REQ-027 In GAP: o_pix_ready=0; ov_data = TR; ov_ctrl = BL; GAP SHALL last exactly LINE_GAP cycles.
REQ-028 At GAP exit, if lcnt=FRAME_LINES-1, the FSM SHALL go to IDLE and pulse o_frame_done for 1 cycle; otherwise it SHALL increment lcnt and go to ACTIVE.
REQ-029 i_start asserted outside IDLE SHALL be ignored and SHALL not be queued.
REQ-030 Frame length SHALL be exactly FRAME_LINES*(LINE_KERNELS+LINE_GAP) cycles from the first ACTIVE cycle to the IDLE return.
REQ-031 With FRAME_LINES=1, the first line SHALL carry FS at kcnt=0 and FE at its last kernel.

Reset
REQ-032 While reset=1, on each clock edge: state=IDLE; lcnt=kcnt=0; ov_data=TR on all channels; ov_ctrl=BL; o_pix_ready=0; o_busy=0; o_frame_done=0; o_underflow=0.
REQ-033 Reset asserted mid-frame SHALL abort the frame with no FE or o_frame_done; the next frame SHALL start with FS.

Verification
REQ-034 Default parameters, i_start pulse, i_pix_valid held 1 with incrementing data -> ov_ctrl sequence FS, IMG x14, LE, BL x4, then LS ... FE on line 15; o_frame_done pulses once, 320 cycles after the first ACTIVE cycle.
REQ-035 Kernel accepted at cycle N with value 40'h01_2345_6789 -> ov_data=40'h01_2345_6789 at N+1, matching the cycle the corresponding ov_ctrl word appears.
REQ-036 Deassert i_pix_valid for one kernel on line 3 -> that slot ov_data=TR on all channels; o_underflow=1 and stays 1 to the end of the frame; frame timing unchanged.
REQ-037 IDLE with i_train_en=1 -> ov_ctrl=10'h3A6; with i_train_en=0 -> 10'h015; second i_start during ACTIVE -> no effect.
REQ-038 Reset asserted at line 7 kernel 5 -> next cycle ov_ctrl=BL, o_busy=0; the following i_start yields FS first.
REQ-039 FRAME_LINES=1, LINE_KERNELS=2 -> ov_ctrl FS, FE, BL x LINE_GAP, then o_frame_done.
